l1_veri_denetleyici: RTL and testbench
======================================

L1_VERI_DENETLEYICI -- requirements
Module: l1_veri_denetleyici

Interface
REQ-001 SHALL have parameter SATIR_SAYISI, default 64, meaning the number of direct-mapped lines (power of two).
REQ-002 SHALL have ports: clk_i, input, 1, the single clock.
REQ-003 SHALL have ports: rst_i, input, 1, synchronous reset, active-high.
REQ-004 SHALL have: cpu_istek_adres_i, input, `ADRES_BIT, byte address; bits [1:0] ignored.
REQ-005 SHALL have: cpu_istek_veri_i, input, `VERI_BIT, store data.
REQ-006 SHALL have: cpu_istek_maske_i, input, `VERI_BYTE, byte-enable for stores.
REQ-007 SHALL have: cpu_istek_yaz_i, input, 1, 1=store, 0=load.
REQ-008 SHALL have: cpu_istek_gecerli_i input 1 and cpu_istek_hazir_o output 1, request handshake.
REQ-009 SHALL have: cpu_veri_o, output, `VERI_BIT, load data (stores return the merged word).
REQ-010 SHALL have: cpu_veri_gecerli_o output 1 and cpu_veri_hazir_i input 1, response handshake.
REQ-011 SHALL have: vy_istek_adres_o output `ADRES_BIT; vy_istek_veri_o output `L1_BLOK_BIT; vy_istek_yaz_o output 1; vy_istek_gecerli_o output 1; vy_istek_hazir_i input 1, the block request to the bus controller.
REQ-012 SHALL have: vy_veri_i input `L1_BLOK_BIT; vy_veri_gecerli_i input 1; vy_veri_hazir_o output 1, the block fill from the bus controller.

Function
REQ-013 SHALL decode the address as: word select = [log2(`L1_BLOK_BIT/8)-1:2]; index = next log2(SATIR_SAYISI) bits; tag = remaining upper bits.
REQ-014 SHALL hold per line: a valid bit, a dirty bit, a tag, and one `L1_BLOK_BIT data block, all in flip-flops.
REQ-015 SHALL use FSM states BOSTA, KARSILASTIR, GERI_YAZ, BLOK_OKU_ISTEK, BLOK_OKU_BEKLE, YANIT.
REQ-016 BOSTA: cpu_istek_hazir_o=1; when gecerli&&hazir, SHALL latch addr/data/mask/write, drop hazir, and go to KARSILASTIR.
REQ-017 KARSILASTIR on hit (valid && tag equal): load SHALL register the selected word; store SHALL merge the masked bytes into the line, set dirty=1, and register the merged word; next state YANIT.
REQ-018 KARSILASTIR on miss: SHALL go to GERI_YAZ if the line is valid&&dirty, else to BLOK_OKU_ISTEK.
REQ-019 Hit latency: accept at edge N, cpu_veri_gecerli_o SHALL be high from edge N+2.
REQ-020 GERI_YAZ: vy_istek_gecerli_o=1, yaz=1, adres={old tag,index,0}, veri=old block; on vy_istek_hazir_i SHALL drop gecerli, clear dirty, and go to BLOK_OKU_ISTEK.
REQ-021 BLOK_OKU_ISTEK: gecerli=1, yaz=0, adres = block-aligned request address; on hazir SHALL drop gecerli and go to BLOK_OKU_BEKLE.
REQ-022 BLOK_OKU_BEKLE: vy_veri_hazir_o=1; on vy_veri_gecerli_i SHALL write the block, valid=1, dirty=0, new tag, then return to KARSILASTIR (guaranteed hit).
REQ-023 YANIT: cpu_veri_gecerli_o and cpu_veri_o SHALL hold stable until cpu_veri_hazir_i, then go to BOSTA; no new request is accepted before this.
REQ-024 vy_istek_* outputs SHALL stay stable while gecerli=1 and hazir=0.
REQ-025 A store with mask 0 SHALL still complete as a hit/miss with no byte change; dirty is set only if the mask is nonzero.
REQ-026 Only one outstanding CPU request; only one outstanding bus request.

Reset
REQ-027 While rst_i=1 at a clock edge: state=BOSTA, all valid/dirty=0, and every output =0 (including cpu_istek_hazir_o); cpu_istek_hazir_o SHALL rise on the first edge after rst_i falls.
REQ-028 Reset mid-miss SHALL abandon the bus transaction (gecerli low the next cycle); the tag and data arrays need no reset.

Structure
REQ-029 `ADRES_BIT, `VERI_BIT, `VERI_BYTE, `L1_BLOK_BIT, `HIGH, `LOW SHALL come from sabitler.vh; state encodings are local.
REQ-030 A sub-module l1_satir_dizisi (tag/valid/dirty/data storage with a write port and an asynchronous read) is natural; single-module is acceptable.

Verification
REQ-031 Load 0x0000_0040 after reset -> miss, no write-back, read request adres 0x0000_0040; fill 0x…DDDD_CCCC_BBBB_AAAA -> cpu_veri_o=0xAAAA_AAAA.
REQ-032 Repeat load 0x0000_0044 -> hit, gecerli at N+2, no bus activity, data = word 1 of the block.
REQ-033 Store 0x0000_0040, data 0x1122_3344, mask 4'b0011 -> merged word 0xAAAA_3344, dirty set.
REQ-034 Load 0x0000_0440 (same index, different tag) -> write-back to 0x0000_0040 with the merged block, then a read request to 0x0000_0440.
REQ-035 Hold vy_istek_hazir_i and cpu_veri_hazir_i low for 5 cycles -> outputs stable, no duplicate requests.
REQ-036 Assert rst_i during BLOK_OKU_BEKLE -> all outputs 0 the next cycle; a subsequent load to the same address misses.

Source files
------------

// File: rtl/l1_veri_denetleyici_pkg.sv
// Widths, FSM states and byte-merge helper for the L1 data cache controller.
`include "sabitler.vh"

package l1_veri_denetleyici_pkg;

    localparam int unsigned ADRES_W        = `ADRES_BIT;
    localparam int unsigned VERI_W         = `VERI_BIT;
    localparam int unsigned VERI_BYTE_W    = `VERI_BYTE;
    localparam int unsigned BLOK_W         = `L1_BLOK_BIT;
    localparam int unsigned OFSET_BIT      = $clog2(BLOK_W / 8);
    localparam int unsigned KELIME_SAYISI  = BLOK_W / VERI_W;
    localparam int unsigned KELIME_SEC_BIT = $clog2(KELIME_SAYISI);

    typedef enum logic [2:0] {
        BOSTA,
        KARSILASTIR,
        GERI_YAZ,
        BLOK_OKU_ISTEK,
        BLOK_OKU_BEKLE,
        YANIT
    } durum_t;

    // Replace the bytes of eski selected by maske with those of yeni.
    function automatic logic [VERI_W-1:0] bayt_birlestir(
        input logic [VERI_W-1:0]      eski,
        input logic [VERI_W-1:0]      yeni,
        input logic [VERI_BYTE_W-1:0] maske
    );
        logic [VERI_W-1:0] sonuc;
        sonuc = eski;
        for (int b = 0; b < int'(VERI_BYTE_W); b++) begin
            if (maske[b]) sonuc[b*8 +: 8] = yeni[b*8 +: 8];
        end
        return sonuc;
    endfunction

endpackage

// File: rtl/l1_satir_dizisi.sv
// Direct-mapped line storage: valid/dirty/tag/block per line, one write port, async read.
`include "sabitler.vh"

module l1_satir_dizisi
    import l1_veri_denetleyici_pkg::*;
#(
    parameter int unsigned SATIR_SAYISI = 64,
    parameter int unsigned INDEKS_BIT   = $clog2(SATIR_SAYISI),
    parameter int unsigned ETIKET_BIT   = ADRES_W - INDEKS_BIT - OFSET_BIT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEKS_BIT-1:0] indeks,
    input  logic                  yaz_en,
    input  logic                  yaz_gecerli,
    input  logic                  yaz_kirli,
    input  logic [ETIKET_BIT-1:0] yaz_etiket,
    input  logic [BLOK_W-1:0]     yaz_blok,
    output logic                  oku_gecerli,
    output logic                  oku_kirli,
    output logic [ETIKET_BIT-1:0] oku_etiket,
    output logic [BLOK_W-1:0]     oku_blok
);

    logic [SATIR_SAYISI-1:0] gecerli_q;
    logic [SATIR_SAYISI-1:0] kirli_q;
    logic [ETIKET_BIT-1:0]   etiket_q [SATIR_SAYISI];
    logic [BLOK_W-1:0]       blok_q   [SATIR_SAYISI];

    // Only the status bits are reset; tags and data are qualified by valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_q <= '0;
            kirli_q   <= '0;
        end else if (yaz_en) begin
            gecerli_q[indeks] <= yaz_gecerli;
            kirli_q[indeks]   <= yaz_kirli;
        end
    end

    always_ff @(posedge clk_i) begin
        if (yaz_en) begin
            etiket_q[indeks] <= yaz_etiket;
            blok_q[indeks]   <= yaz_blok;
        end
    end

    assign oku_gecerli = gecerli_q[indeks];
    assign oku_kirli   = kirli_q[indeks];
    assign oku_etiket  = etiket_q[indeks];
    assign oku_blok    = blok_q[indeks];

endmodule

// File: rtl/sabitler.vh
// Shared width constants for the L1 data cache slice.
`ifndef SABITLER_VH
`define SABITLER_VH
`define ADRES_BIT   32
`define VERI_BIT    32
`define VERI_BYTE   4
`define L1_BLOK_BIT 128
`define HIGH        1'b1
`define LOW         1'b0
`endif

// File: rtl/l1_veri_denetleyici.sv
// Blocking direct-mapped write-back L1 data cache controller with a single-block bus port.
`include "sabitler.vh"

module l1_veri_denetleyici
    import l1_veri_denetleyici_pkg::*;
#(
    parameter int unsigned SATIR_SAYISI = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADRES_W-1:0]     cpu_istek_adres_i,
    input  logic [VERI_W-1:0]      cpu_istek_veri_i,
    input  logic [VERI_BYTE_W-1:0] cpu_istek_maske_i,
    input  logic                   cpu_istek_yaz_i,
    input  logic                   cpu_istek_gecerli_i,
    output logic                   cpu_istek_hazir_o,
    output logic [VERI_W-1:0]      cpu_veri_o,
    output logic                   cpu_veri_gecerli_o,
    input  logic                   cpu_veri_hazir_i,
    output logic [ADRES_W-1:0]     vy_istek_adres_o,
    output logic [BLOK_W-1:0]      vy_istek_veri_o,
    output logic                   vy_istek_yaz_o,
    output logic                   vy_istek_gecerli_o,
    input  logic                   vy_istek_hazir_i,
    input  logic [BLOK_W-1:0]      vy_veri_i,
    input  logic                   vy_veri_gecerli_i,
    output logic                   vy_veri_hazir_o
);

    localparam int unsigned INDEKS_BIT = $clog2(SATIR_SAYISI);
    localparam int unsigned ETIKET_BIT = ADRES_W - INDEKS_BIT - OFSET_BIT;

    durum_t                 durum;
    logic [ADRES_W-1:0]     istek_adres_q;
    logic [VERI_W-1:0]      istek_veri_q;
    logic [VERI_BYTE_W-1:0] istek_maske_q;
    logic                   istek_yaz_q;

    logic [KELIME_SEC_BIT-1:0] kelime_sec;
    logic [INDEKS_BIT-1:0]     indeks;
    logic [ETIKET_BIT-1:0]     etiket;
    logic                      adres_bayt_unused;

    logic                  oku_gecerli;
    logic                  oku_kirli;
    logic [ETIKET_BIT-1:0] oku_etiket;
    logic [BLOK_W-1:0]     oku_blok;

    logic                  yaz_en;
    logic                  yaz_gecerli;
    logic                  yaz_kirli;
    logic [ETIKET_BIT-1:0] yaz_etiket;
    logic [BLOK_W-1:0]     yaz_blok;

    logic              isabet;
    logic [VERI_W-1:0] secili_kelime;
    logic [VERI_W-1:0] birlesik_kelime;
    logic [BLOK_W-1:0] birlesik_blok;

    assign kelime_sec        = istek_adres_q[OFSET_BIT-1:2];
    assign indeks            = istek_adres_q[OFSET_BIT +: INDEKS_BIT];
    assign etiket            = istek_adres_q[ADRES_W-1 -: ETIKET_BIT];
    assign adres_bayt_unused = ^istek_adres_q[1:0];
    assign isabet            = oku_gecerli && (oku_etiket == etiket);

    l1_satir_dizisi #(
        .SATIR_SAYISI (SATIR_SAYISI),
        .INDEKS_BIT   (INDEKS_BIT),
        .ETIKET_BIT   (ETIKET_BIT)
    ) u_satir_dizisi (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .indeks      (indeks),
        .yaz_en      (yaz_en),
        .yaz_gecerli (yaz_gecerli),
        .yaz_kirli   (yaz_kirli),
        .yaz_etiket  (yaz_etiket),
        .yaz_blok    (yaz_blok),
        .oku_gecerli (oku_gecerli),
        .oku_kirli   (oku_kirli),
        .oku_etiket  (oku_etiket),
        .oku_blok    (oku_blok)
    );

    // Word select and store merge on the currently indexed line.
    always_comb begin
        secili_kelime = '0;
        for (int k = 0; k < int'(KELIME_SAYISI); k++) begin
            if (kelime_sec == KELIME_SEC_BIT'(k)) secili_kelime = oku_blok[k*VERI_W +: VERI_W];
        end
        birlesik_kelime = bayt_birlestir(secili_kelime, istek_veri_q, istek_maske_q);
        birlesik_blok   = oku_blok;
        for (int k = 0; k < int'(KELIME_SAYISI); k++) begin
            if (kelime_sec == KELIME_SEC_BIT'(k)) birlesik_blok[k*VERI_W +: VERI_W] = birlesik_kelime;
        end
    end

    // Line updates: store hit, write-back completion, block fill.
    always_comb begin
        yaz_en      = `LOW;
        yaz_gecerli = oku_gecerli;
        yaz_kirli   = oku_kirli;
        yaz_etiket  = oku_etiket;
        yaz_blok    = oku_blok;
        case (durum)
            KARSILASTIR: begin
                if (isabet && istek_yaz_q && (|istek_maske_q)) begin
                    yaz_en    = `HIGH;
                    yaz_kirli = `HIGH;
                    yaz_blok  = birlesik_blok;
                end
            end
            GERI_YAZ: begin
                if (vy_istek_gecerli_o && vy_istek_hazir_i) begin
                    yaz_en    = `HIGH;
                    yaz_kirli = `LOW;
                end
            end
            BLOK_OKU_BEKLE: begin
                if (vy_veri_hazir_o && vy_veri_gecerli_i) begin
                    yaz_en      = `HIGH;
                    yaz_gecerli = `HIGH;
                    yaz_kirli   = `LOW;
                    yaz_etiket  = etiket;
                    yaz_blok    = vy_veri_i;
                end
            end
            default: ;
        endcase
    end

    // Control FSM; every output is a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum              <= BOSTA;
            istek_adres_q      <= '0;
            istek_veri_q       <= '0;
            istek_maske_q      <= '0;
            istek_yaz_q        <= `LOW;
            cpu_istek_hazir_o  <= `LOW;
            cpu_veri_o         <= '0;
            cpu_veri_gecerli_o <= `LOW;
            vy_istek_adres_o   <= '0;
            vy_istek_veri_o    <= '0;
            vy_istek_yaz_o     <= `LOW;
            vy_istek_gecerli_o <= `LOW;
            vy_veri_hazir_o    <= `LOW;
        end else begin
            case (durum)
                BOSTA: begin
                    if (cpu_istek_gecerli_i && cpu_istek_hazir_o) begin
                        istek_adres_q     <= cpu_istek_adres_i;
                        istek_veri_q      <= cpu_istek_veri_i;
                        istek_maske_q     <= cpu_istek_maske_i;
                        istek_yaz_q       <= cpu_istek_yaz_i;
                        cpu_istek_hazir_o <= `LOW;
                        durum             <= KARSILASTIR;
                    end else begin
                        cpu_istek_hazir_o <= `HIGH;
                    end
                end
                KARSILASTIR: begin
                    if (isabet) begin
                        cpu_veri_o         <= istek_yaz_q ? birlesik_kelime : secili_kelime;
                        cpu_veri_gecerli_o <= `HIGH;
                        durum              <= YANIT;
                    end else if (oku_gecerli && oku_kirli) begin
                        durum <= GERI_YAZ;
                    end else begin
                        durum <= BLOK_OKU_ISTEK;
                    end
                end
                GERI_YAZ: begin
                    if (!vy_istek_gecerli_o) begin
                        vy_istek_gecerli_o <= `HIGH;
                        vy_istek_yaz_o     <= `HIGH;
                        vy_istek_adres_o   <= {oku_etiket, indeks, {OFSET_BIT{1'b0}}};
                        vy_istek_veri_o    <= oku_blok;
                    end else if (vy_istek_hazir_i) begin
                        vy_istek_gecerli_o <= `LOW;
                        durum              <= BLOK_OKU_ISTEK;
                    end
                end
                BLOK_OKU_ISTEK: begin
                    if (!vy_istek_gecerli_o) begin
                        vy_istek_gecerli_o <= `HIGH;
                        vy_istek_yaz_o     <= `LOW;
                        vy_istek_adres_o   <= {istek_adres_q[ADRES_W-1:OFSET_BIT], {OFSET_BIT{1'b0}}};
                        vy_istek_veri_o    <= '0;
                    end else if (vy_istek_hazir_i) begin
                        vy_istek_gecerli_o <= `LOW;
                        vy_veri_hazir_o    <= `HIGH;
                        durum              <= BLOK_OKU_BEKLE;
                    end
                end
                BLOK_OKU_BEKLE: begin
                    if (vy_veri_gecerli_i) begin
                        vy_veri_hazir_o <= `LOW;
                        durum           <= KARSILASTIR;
                    end
                end
                YANIT: begin
                    if (cpu_veri_hazir_i) begin
                        cpu_veri_gecerli_o <= `LOW;
                        cpu_istek_hazir_o  <= `HIGH;
                        durum              <= BOSTA;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_veri_denetleyici.sv
// Scoreboard bench: driver queues expected CPU/bus traffic, monitor and bus model check it.
`timescale 1ns/1ps

module tb_l1_veri_denetleyici;

    typedef struct {
        logic [31:0] veri;
        bit          isabet;
        int          bekle;
    } cpu_bek_t;

    typedef struct {
        logic [31:0]  adres;
        logic         yaz;
        logic [127:0] veri;
    } vy_bek_t;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  cpu_istek_adres_i;
    logic [31:0]  cpu_istek_veri_i;
    logic [3:0]   cpu_istek_maske_i;
    logic         cpu_istek_yaz_i;
    logic         cpu_istek_gecerli_i;
    logic         cpu_istek_hazir_o;
    logic [31:0]  cpu_veri_o;
    logic         cpu_veri_gecerli_o;
    logic         cpu_veri_hazir_i;
    logic [31:0]  vy_istek_adres_o;
    logic [127:0] vy_istek_veri_o;
    logic         vy_istek_yaz_o;
    logic         vy_istek_gecerli_o;
    logic         vy_istek_hazir_i;
    logic [127:0] vy_veri_i;
    logic         vy_veri_gecerli_i;
    logic         vy_veri_hazir_o;

    cpu_bek_t     cpu_q[$];
    vy_bek_t      vy_q[$];
    logic [127:0] bellek [logic [31:0]];

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;
    int cyc            = 0;
    int kabul_kenari   = 0;
    int vy_bekle       = 0;
    bit tut_dolum      = 0;

    l1_veri_denetleyici #(.SATIR_SAYISI(64)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cpu_istek_adres_i   (cpu_istek_adres_i),
        .cpu_istek_veri_i    (cpu_istek_veri_i),
        .cpu_istek_maske_i   (cpu_istek_maske_i),
        .cpu_istek_yaz_i     (cpu_istek_yaz_i),
        .cpu_istek_gecerli_i (cpu_istek_gecerli_i),
        .cpu_istek_hazir_o   (cpu_istek_hazir_o),
        .cpu_veri_o          (cpu_veri_o),
        .cpu_veri_gecerli_o  (cpu_veri_gecerli_o),
        .cpu_veri_hazir_i    (cpu_veri_hazir_i),
        .vy_istek_adres_o    (vy_istek_adres_o),
        .vy_istek_veri_o     (vy_istek_veri_o),
        .vy_istek_yaz_o      (vy_istek_yaz_o),
        .vy_istek_gecerli_o  (vy_istek_gecerli_o),
        .vy_istek_hazir_i    (vy_istek_hazir_i),
        .vy_veri_i           (vy_veri_i),
        .vy_veri_gecerli_i   (vy_veri_gecerli_i),
        .vy_veri_hazir_o     (vy_veri_hazir_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc++;

    task automatic kontrol(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
        kontrol_sayisi++;
        if (gercek !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gercek=%h beklenen=%h (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    // Backing memory: written-back blocks, else the fixed pattern at 0x40, else address-as-data.
    function automatic logic [127:0] bellek_oku(input logic [31:0] a);
        if (bellek.exists(a)) return bellek[a];
        if (a == 32'h0000_0040) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    task automatic cpu_bek(input logic [31:0] v, input bit isabet, input int bekle);
        cpu_bek_t e;
        e.veri = v; e.isabet = isabet; e.bekle = bekle;
        cpu_q.push_back(e);
    endtask

    task automatic vy_bek(input logic [31:0] a, input logic y, input logic [127:0] v);
        vy_bek_t e;
        e.adres = a; e.yaz = y; e.veri = v;
        vy_q.push_back(e);
    endtask

    task automatic istek(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m, input logic y);
        int n = 0;
        while (!cpu_istek_hazir_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) begin
            kontrol("istek_hazir_zaman_asimi", 128'(cpu_istek_hazir_o), 128'(1));
            return;
        end
        cpu_istek_adres_i   = a;
        cpu_istek_veri_i    = v;
        cpu_istek_maske_i   = m;
        cpu_istek_yaz_i     = y;
        cpu_istek_gecerli_i = 1'b1;
        kabul_kenari        = cyc + 1;
        @(negedge clk_i);
        cpu_istek_gecerli_i = 1'b0;
    endtask

    task automatic bosta_bekle();
        int n = 0;
        while (!cpu_istek_hazir_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) kontrol("bosta_zaman_asimi", 128'(cpu_istek_hazir_o), 128'(1));
    endtask

    // CPU response monitor.
    initial begin
        cpu_bek_t    c;
        logic [31:0] yakalanan;
        cpu_veri_hazir_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && cpu_veri_gecerli_o) begin
                if (cpu_q.size() == 0) begin
                    kontrol("cpu_fazla_yanit", 128'(cpu_veri_o), 128'hx);
                end else begin
                    c = cpu_q.pop_front();
                    kontrol("cpu_veri", 128'(cpu_veri_o), 128'(c.veri));
                    if (c.isabet) kontrol("isabet_gecikme", 128'(cyc - kabul_kenari), 128'(1));
                    yakalanan = cpu_veri_o;
                    for (int i = 0; i < c.bekle; i++) begin
                        @(negedge clk_i);
                        kontrol("cpu_yanit_sabit", {95'd0, cpu_veri_gecerli_o, cpu_veri_o}, {95'd0, 1'b1, yakalanan});
                    end
                end
                cpu_veri_hazir_i = 1'b1;
                @(negedge clk_i);
                cpu_veri_hazir_i = 1'b0;
            end
        end
    end

    // Bus controller model with request checking.
    initial begin
        vy_bek_t      e;
        logic [31:0]  cap_adres;
        logic [127:0] cap_veri;
        logic         cap_yaz;
        int           n;
        bit           iptal;
        vy_istek_hazir_i  = 1'b0;
        vy_veri_gecerli_i = 1'b0;
        vy_veri_i         = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && vy_istek_gecerli_o) begin
                cap_adres = vy_istek_adres_o;
                cap_veri  = vy_istek_veri_o;
                cap_yaz   = vy_istek_yaz_o;
                iptal     = 0;
                if (vy_q.size() == 0) begin
                    kontrol("vy_fazla_istek", 128'(cap_adres), 128'hx);
                end else begin
                    e = vy_q.pop_front();
                    kontrol("vy_adres", 128'(cap_adres), 128'(e.adres));
                    kontrol("vy_yaz", 128'(cap_yaz), 128'(e.yaz));
                    if (e.yaz) kontrol("vy_veri", cap_veri, e.veri);
                end
                for (int i = 0; i < vy_bekle && !iptal; i++) begin
                    @(negedge clk_i);
                    if (rst_i) iptal = 1;
                    else begin
                        kontrol("vy_istek_sabit", {94'd0, vy_istek_gecerli_o, vy_istek_yaz_o, vy_istek_adres_o},
                                {94'd0, 1'b1, cap_yaz, cap_adres});
                        kontrol("vy_veri_sabit", vy_istek_veri_o, cap_veri);
                    end
                end
                if (!iptal) begin
                    vy_istek_hazir_i = 1'b1;
                    @(negedge clk_i);
                    vy_istek_hazir_i = 1'b0;
                    if (cap_yaz) begin
                        bellek[cap_adres] = cap_veri;
                    end else begin
                        n = 0;
                        while (!(vy_veri_hazir_o && !tut_dolum) && !rst_i && n < 300) begin
                            @(negedge clk_i);
                            n++;
                        end
                        if (n >= 300) kontrol("dolum_zaman_asimi", 128'(vy_veri_hazir_o), 128'(1));
                        else if (!rst_i) begin
                            vy_veri_i         = bellek_oku(cap_adres);
                            vy_veri_gecerli_i = 1'b1;
                            @(negedge clk_i);
                            vy_veri_gecerli_i = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int n;
        rst_i               = 1'b1;
        cpu_istek_adres_i   = '0;
        cpu_istek_veri_i    = '0;
        cpu_istek_maske_i   = '0;
        cpu_istek_yaz_i     = 1'b0;
        cpu_istek_gecerli_i = 1'b0;
        repeat (3) @(negedge clk_i);
        kontrol("reset_cpu_hazir", 128'(cpu_istek_hazir_o), 128'(0));
        kontrol("reset_cpu_cikis", {95'd0, cpu_veri_gecerli_o, cpu_veri_o}, 128'(0));
        kontrol("reset_vy_cikis", {92'd0, vy_istek_gecerli_o, vy_istek_yaz_o, vy_veri_hazir_o, 1'b0, vy_istek_adres_o}, 128'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        kontrol("reset_sonrasi_hazir", 128'(cpu_istek_hazir_o), 128'(1));

        // Cold miss, clean line: read request only.
        vy_bek(32'h0000_0040, 1'b0, '0);
        cpu_bek(32'hAAAA_AAAA, 0, 0);
        istek(32'h0000_0040, 32'h0, 4'h0, 1'b0);
        // Load hit on word 1.
        cpu_bek(32'hBBBB_BBBB, 1, 0);
        istek(32'h0000_0044, 32'h0, 4'h0, 1'b0);
        // Store hit, low two bytes.
        cpu_bek(32'hAAAA_3344, 1, 0);
        istek(32'h0000_0040, 32'h1122_3344, 4'b0011, 1'b1);

        // Conflict miss on a dirty line, with stalled bus and CPU handshakes.
        bosta_bekle();
        vy_bekle = 5;
        vy_bek(32'h0000_0040, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAA3344);
        vy_bek(32'h0000_0440, 1'b0, '0);
        cpu_bek(32'h0000_0440, 0, 5);
        istek(32'h0000_0440, 32'h0, 4'h0, 1'b0);
        bosta_bekle();
        vy_bekle = 0;

        // Refetch of the written-back block.
        vy_bek(32'h0000_0040, 1'b0, '0);
        cpu_bek(32'hAAAA_3344, 0, 0);
        istek(32'h0000_0040, 32'h0, 4'h0, 1'b0);
        // Zero-mask store: hit, no change, line stays clean.
        cpu_bek(32'hCCCC_CCCC, 1, 0);
        istek(32'h0000_0048, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        // Clean eviction: no write-back expected.
        vy_bek(32'h0000_0440, 1'b0, '0);
        cpu_bek(32'h0000_0448, 0, 0);
        istek(32'h0000_0448, 32'h0, 4'h0, 1'b0);
        // Store miss, full mask, then load hit.
        vy_bek(32'h0000_0070, 1'b0, '0);
        cpu_bek(32'hDEAD_BEEF, 0, 0);
        istek(32'h0000_007C, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        cpu_bek(32'hDEAD_BEEF, 1, 0);
        istek(32'h0000_007C, 32'h0, 4'h0, 1'b0);

        // Reset while waiting for a block fill.
        bosta_bekle();
        tut_dolum = 1;
        vy_bek(32'h0000_0080, 1'b0, '0);
        istek(32'h0000_0080, 32'h0, 4'h0, 1'b0);
        n = 0;
        while (!vy_veri_hazir_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        kontrol("dolum_bekleme_durumu", 128'(vy_veri_hazir_o), 128'(1));
        rst_i = 1'b1;
        @(negedge clk_i);
        kontrol("orta_reset_cpu", {94'd0, cpu_istek_hazir_o, cpu_veri_gecerli_o, cpu_veri_o}, 128'(0));
        kontrol("orta_reset_vy_kontrol", {93'd0, vy_istek_gecerli_o, vy_istek_yaz_o, vy_veri_hazir_o, vy_istek_adres_o}, 128'(0));
        kontrol("orta_reset_vy_veri", vy_istek_veri_o, 128'(0));
        @(negedge clk_i);
        rst_i     = 1'b0;
        tut_dolum = 0;
        @(negedge clk_i);
        kontrol("orta_reset_sonrasi_hazir", 128'(cpu_istek_hazir_o), 128'(1));
        // Previously cached line must miss after reset.
        vy_bek(32'h0000_0040, 1'b0, '0);
        cpu_bek(32'hAAAA_3344, 0, 0);
        istek(32'h0000_0040, 32'h0, 4'h0, 1'b0);

        bosta_bekle();
        repeat (5) @(negedge clk_i);
        kontrol("cpu_kuyruk_bos", 128'(cpu_q.size()), 128'(0));
        kontrol("vy_kuyruk_bos", 128'(vy_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
